// File: rtl/store_merge_unit_pkg.sv
// Shared encodings for the sub-word store path: store size codes and FSM states.
package store_merge_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/store_merge_unit_lane_merge.sv
// Little-endian lane insert: replaces one byte or halfword lane of an old word.
module lane_merge
    import store_merge_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);

    logic [31:0] mask;
    logic [31:0] shifted;

    always_comb begin
        mask    = 32'h0;
        shifted = 32'h0;
        merged  = data;
        if (size == SZ_BYTE) begin
            mask    = 32'h0000_00FF << {lane, 3'b000};
            shifted = {24'h0, data[7:0]} << {lane, 3'b000};
            merged  = (old_word & ~mask) | (shifted & mask);
        end else if (size == SZ_HALF) begin
            // Halfword lane is selected by lane[1] only; lane[0] is zero for legal halves.
            mask    = 32'h0000_FFFF << {lane[1], 4'b0000};
            shifted = {16'h0, data[15:0]} << {lane[1], 4'b0000};
            merged  = (old_word & ~mask) | (shifted & mask);
        end
    end

endmodule

// File: rtl/store_merge_unit.sv
// Store path for sb/sh/sw: word stores write directly, sub-word stores read-merge-write.
module store_merge_unit
    import store_merge_unit_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_t      state, state_nxt;
    logic [2:0]  cnt;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;
    logic [31:0] rd_q;
    logic        err_q;
    logic        bad_req;
    logic [31:0] merged;

    always_comb begin
        bad_req = (size == 2'b11) ||
                  (size == SZ_HALF && addr[0]) ||
                  (size == SZ_WORD && addr[1:0] != 2'b00);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (bad_req)              state_nxt = DONE;
                    else if (size == SZ_WORD) state_nxt = WRITE;
                    else                      state_nxt = READ;
                end
            end
            READ:    state_nxt = WAIT;
            WAIT:    if (cnt == 3'd1) state_nxt = WRITE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cnt     <= 3'd0;
            addr_q  <= 32'h0;
            size_q  <= 2'b00;
            wdata_q <= 32'h0;
            rd_q    <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                addr_q  <= addr;
                size_q  <= size;
                wdata_q <= wdata;
                err_q   <= bad_req;
            end
            if (state == READ) begin
                cnt <= 3'(RD_LATENCY);
            end
            // Counter reaching 1 marks the cycle the memory drives valid read data.
            if (state == WAIT) begin
                cnt <= cnt - 3'd1;
                if (cnt == 3'd1) rd_q <= mem_rdata;
            end
        end
    end

    lane_merge u_lane_merge (
        .old_word (rd_q),
        .data     (wdata_q),
        .size     (size_q),
        .lane     (addr_q[1:0]),
        .merged   (merged)
    );

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        err       = (state == DONE) && err_q;
        mem_rd    = (state == READ);
        mem_wr    = (state == WRITE);
        mem_addr  = (state == IDLE) ? 32'h0 : {addr_q[31:2], 2'b00};
        mem_wdata = (state == WRITE) ? merged : 32'h0;
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: one instance at RD_LATENCY=1 and one at RD_LATENCY=3.
module tb_store_merge_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        req1, req3;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        busy1, done1, err1, mem_rd1, mem_wr1;
    logic        busy3, done3, err3, mem_rd3, mem_wr3;
    logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;
    logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;
    logic [31:0] word1, word3;
    logic [31:0] p0, p1, p2;

    int errors = 0;
    int checks = 0;
    bit cur = 1'b0;

    always #5 CLK = ~CLK;

    store_merge_unit #(.RD_LATENCY(1)) dut1 (
        .CLK(CLK), .Reset(Reset), .req(req1), .size(size), .addr(addr), .wdata(wdata),
        .busy(busy1), .done(done1), .err(err1), .mem_addr(mem_addr1), .mem_rd(mem_rd1),
        .mem_wr(mem_wr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    store_merge_unit #(.RD_LATENCY(3)) dut3 (
        .CLK(CLK), .Reset(Reset), .req(req3), .size(size), .addr(addr), .wdata(wdata),
        .busy(busy3), .done(done3), .err(err3), .mem_addr(mem_addr3), .mem_rd(mem_rd3),
        .mem_wr(mem_wr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    // Memory models: data is valid only in the cycle RD_LATENCY after mem_rd, garbage otherwise.
    always @(posedge CLK) begin
        mem_rdata1 <= mem_rd1 ? word1 : 32'hBAD0_BAD0;
        p0 <= mem_rd3 ? word3 : 32'hBAD3_BAD3;
        p1 <= p0;
        p2 <= p1;
    end
    assign mem_rdata3 = p2;

    wire        s_rd    = cur ? mem_rd3    : mem_rd1;
    wire        s_wr    = cur ? mem_wr3    : mem_wr1;
    wire        s_done  = cur ? done3      : done1;
    wire        s_err   = cur ? err3       : err1;
    wire [31:0] s_addr  = cur ? mem_addr3  : mem_addr1;
    wire [31:0] s_wdata = cur ? mem_wdata3 : mem_wdata1;

    typedef struct {
        bit          sel;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] old;
        bit          pulse;
        int          exp_done;
        int          exp_rd;
        int          exp_wr;
        logic        exp_err;
        logic [31:0] exp_wv;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int done_c = 0, rd_c = 0, wr_c = 0, rd_n = 0, wr_n = 0;
        logic [31:0] wv = 32'h0, rda = 32'h0, wra = 32'h0, wa;
        logic errv = 1'b0;
        bit overlap = 1'b0;
        wa = {v.a[31:2], 2'b00};
        @(negedge CLK);
        cur = v.sel;
        if (v.sel) word3 = v.old; else word1 = v.old;
        size = v.sz; addr = v.a; wdata = v.wd;
        if (v.sel) req3 = 1'b1; else req1 = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        req1 = 1'b0; req3 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (s_rd && s_wr) overlap = 1'b1;
            if (s_rd) begin rd_c = c; rd_n++; rda = s_addr; end
            if (s_wr) begin wr_c = c; wr_n++; wv = s_wdata; wra = s_addr; end
            if (s_done) begin done_c = c; errv = s_err; break; end
            if (v.pulse) begin
                if (v.sel) req3 = c[0]; else req1 = c[0];
            end
            @(negedge CLK);
        end
        req1 = 1'b0; req3 = 1'b0;
        chk($sformatf("v%0d done_cycle", idx), done_c, v.exp_done);
        chk($sformatf("v%0d err", idx), {31'h0, errv}, {31'h0, v.exp_err});
        chk($sformatf("v%0d rd_cycle", idx), rd_c, v.exp_rd);
        chk($sformatf("v%0d wr_cycle", idx), wr_c, v.exp_wr);
        chk($sformatf("v%0d rd_count", idx), rd_n, (v.exp_rd != 0) ? 1 : 0);
        chk($sformatf("v%0d wr_count", idx), wr_n, (v.exp_wr != 0) ? 1 : 0);
        chk($sformatf("v%0d rd_wr_overlap", idx), {31'h0, overlap}, 32'h0);
        if (v.exp_wr != 0) begin
            chk($sformatf("v%0d mem_wdata", idx), wv, v.exp_wv);
            chk($sformatf("v%0d wr_addr", idx), wra, wa);
        end
        if (v.exp_rd != 0) chk($sformatf("v%0d rd_addr", idx), rda, wa);
    endtask

    vec_t vecs[$];
    vec_t wv_after;
    bit saw_wr;

    initial begin
        vecs.push_back('{0, 2'b00, 32'h0000_0102, 32'hABCD_EFAA, 32'h1122_3344, 0, 4, 1, 3, 1'b0, 32'h11AA_3344});
        vecs.push_back('{0, 2'b01, 32'h0000_0202, 32'h0000_1234, 32'hDEAD_BEEF, 0, 4, 1, 3, 1'b0, 32'h1234_BEEF});
        vecs.push_back('{0, 2'b10, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,         0, 2, 0, 1, 1'b0, 32'hCAFE_F00D});
        vecs.push_back('{0, 2'b01, 32'h0000_0101, 32'h0000_5555, 32'h0,         0, 1, 0, 0, 1'b1, 32'h0});
        vecs.push_back('{0, 2'b10, 32'h0000_0302, 32'h1234_5678, 32'h0,         0, 1, 0, 0, 1'b1, 32'h0});
        vecs.push_back('{0, 2'b11, 32'h0000_0400, 32'h1234_5678, 32'h0,         0, 1, 0, 0, 1'b1, 32'h0});
        vecs.push_back('{0, 2'b00, 32'h0000_0000, 32'h0000_0055, 32'h0000_0000, 0, 4, 1, 3, 1'b0, 32'h0000_0055});
        vecs.push_back('{0, 2'b00, 32'h0000_0001, 32'hFFFF_FF77, 32'hAAAA_AAAA, 0, 4, 1, 3, 1'b0, 32'hAAAA_77AA});
        vecs.push_back('{0, 2'b00, 32'h0000_0007, 32'h0000_0012, 32'h0102_0304, 0, 4, 1, 3, 1'b0, 32'h1202_0304});
        vecs.push_back('{0, 2'b01, 32'h0000_0200, 32'hFFFF_8765, 32'h1122_3344, 0, 4, 1, 3, 1'b0, 32'h1122_8765});
        vecs.push_back('{0, 2'b01, 32'h0000_0003, 32'h0000_1111, 32'h0,         0, 1, 0, 0, 1'b1, 32'h0});
        vecs.push_back('{0, 2'b00, 32'hFFFF_FFFF, 32'h0000_009A, 32'h0000_0000, 0, 4, 1, 3, 1'b0, 32'h9A00_0000});
        vecs.push_back('{1, 2'b00, 32'h0000_0500, 32'h0000_0000, 32'hFFFF_FFFF, 1, 6, 1, 5, 1'b0, 32'hFFFF_FF00});
        wv_after = '{1, 2'b10, 32'h0000_0600, 32'h0BAD_F00D, 32'h0, 0, 2, 0, 1, 1'b0, 32'h0BAD_F00D};

        Reset = 1'b1; req1 = 1'b0; req3 = 1'b0;
        size = 2'b00; addr = 32'h0; wdata = 32'h0; word1 = 32'h0; word3 = 32'h0;
        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        chk("reset_flags_l1", {27'h0, busy1, done1, err1, mem_rd1, mem_wr1}, 32'h0);
        chk("reset_flags_l3", {27'h0, busy3, done3, err3, mem_rd3, mem_wr3}, 32'h0);
        chk("reset_bus_l1", mem_addr1 | mem_wdata1, 32'h0);
        chk("reset_bus_l3", mem_addr3 | mem_wdata3, 32'h0);

        foreach (vecs[i]) run_op(vecs[i], i);

        // Asynchronous reset in the middle of WAIT must abort without any write.
        @(negedge CLK);
        cur = 1'b1; word3 = 32'h1234_5678;
        size = 2'b00; addr = 32'h0000_0700; wdata = 32'h0000_00EE; req3 = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        req3 = 1'b0;
        @(negedge CLK);
        chk("wait_state_busy", {31'h0, busy3}, 32'h1);
        #2 Reset = 1'b1;
        #1;
        chk("async_rst_busy", {31'h0, busy3}, 32'h0);
        chk("async_rst_strobes", {30'h0, mem_rd3, mem_wr3}, 32'h0);
        chk("async_rst_addr", mem_addr3, 32'h0);
        saw_wr = 1'b0;
        @(negedge CLK);
        Reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (mem_wr3 || busy3) saw_wr = 1'b1;
        end
        chk("no_write_after_abort", {31'h0, saw_wr}, 32'h0);

        run_op(wv_after, 99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Sub-word store path of the multicycle CPU. It is the inverse of the immediate/load extension path: it inserts a byte or halfword from a 32-bit register value into a word-addressed data memory.
- Word stores go straight to memory.
- Byte and halfword stores use a read-modify-write sequence: read the word, merge the lane, write the word back.
- Sits between the datapath's store controls (sb/sh/sw) and the data memory.

Parameters:
RD_LATENCY, 1, cycles from the mem_rd cycle to valid mem_rdata (legal 1..4)

Ports:
CLK  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
req  input  1  store request, sampled only in IDLE
size  input  2  00 byte, 01 half, 10 word, 11 illegal
addr  input  32  byte address
wdata  input  32  register data; byte uses [7:0], half uses [15:0]
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the operation ends
err  output  1  one-cycle pulse together with done on misaligned or illegal size; no memory access
mem_addr  output  32  {addr_q[31:2],2'b00}; 0 in IDLE
mem_rd  output  1  read strobe, high exactly one cycle
mem_wr  output  1  write strobe, high exactly one cycle
mem_wdata  output  32  merged word, valid while mem_wr=1; else 0
mem_rdata  input  32  memory read data

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done, err, mem_rd, mem_wr = 0; mem_addr, mem_wdata, latched regs = 0.
  - Reset before WRITE aborts with no memory write.
  - Strobes are decoded from state only, so they drop immediately on reset.
- IDLE: on req=1, latch addr, size and wdata into addr_q, size_q, wdata_q, then check the request:
  - Illegal size, or misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> DONE with err flag set.
  - Word -> WRITE.
  - Byte or half -> READ.
- READ: mem_rd=1 for 1 cycle -> WAIT. Counter is loaded with RD_LATENCY.
- WAIT: decrement the counter. On the cycle the counter reaches its last count, capture mem_rdata into rd_q -> WRITE.
  - With RD_LATENCY=1, WAIT lasts exactly 1 cycle: the data arrives in the cycle after mem_rd and is captured at the end of that cycle.
- WRITE: mem_wr=1, mem_wdata=merge(rd_q, wdata_q, size_q, addr_q[1:0]) -> DONE.
- DONE: done=1, err=err flag, busy=1 -> IDLE.
  - A req seen in DONE or in any busy state is ignored; the master must hold or re-issue it.
  - Minimum gap between accepted requests is one IDLE cycle.
- Latency, counted from the accept edge to the done cycle:
  - err case: 1 cycle.
  - Word: 2 cycles.
  - Byte/half: 3+RD_LATENCY cycles (4 when RD_LATENCY=1).
- Merge rules (little-endian):
  - Byte: lane = addr_q[1:0], mask = 0xFF<<(8*lane).
  - Half: lane = addr_q[1], mask = 0xFFFF<<(16*lane).
  - Result = (rd_q & ~mask) | ((data<<shift) & mask).
  - Word: result = wdata_q; no read is performed.
- Upper bits of wdata beyond the selected width are ignored.
- addr bits [1:0] never appear on mem_addr.
- mem_rd and mem_wr are never high in the same cycle.

Decomposition:
- Shared package holds:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - state encoding IDLE, READ, WAIT, WRITE, DONE as 3-bit localparams.
- One natural combinational sub-module, lane_merge, computes (old word, data, size, lane) -> merged word. It is reused later by the load-side lane extract.
- The FSM, latency counter and latch registers stay in store_merge_unit.

Test Plan:
- Byte store, RD_LATENCY=1: mem holds 0x11223344 at 0x100; req, size=00, addr=0x102, wdata=0xABCDEFAA.
  - Expect mem_rd in cycle 1 at 0x100; mem_wr in cycle 3 with 0x11AA3344; done in cycle 4; err=0.
- Half store: mem 0xDEADBEEF at 0x200; size=01, addr=0x202, wdata=0x00001234.
  - Expect mem_wdata=0x1234BEEF.
- Word store: size=10, addr=0x300, wdata=0xCAFEF00D.
  - Expect no mem_rd; mem_wr in cycle 1 with 0xCAFEF00D; done in cycle 2.
- Error cases: misaligned half (addr=0x101), misaligned word (addr=0x302), size=11.
  - Each: done=err=1 in cycle 1; mem_rd=mem_wr=0 throughout.
- RD_LATENCY=3, byte store at lane 0, old word 0xFFFFFFFF, wdata=0x00.
  - Expect 0xFFFFFF00; done 6 cycles after accept.
  - Pulse req during busy: no second mem_rd.
- Assert Reset asynchronously during WAIT.
  - Expect busy=0 immediately, no mem_wr ever.
  - A new word store then completes normally.
